// File: rtl/sc_dot_host.sv
`default_nettype none
// ============================================================================
// Module   : sc_dot_host
// Brief    : Requester/checker for the stochastic 4-term dot-product core.
//            Issues LFSR-generated operand sets over the en_in/en_out
//            handshake, computes the exact truncated reference for each set
//            and accumulates the absolute error over N_SAMPLES sets.
// Revision : 1.0 - initial release
// ============================================================================
module sc_dot_host #(
    parameter int          N_SAMPLES = 1000,
    parameter logic [47:0] SEED      = 48'h5A5A_C3C3_0F0F,
    parameter int          SUMW      = 20,
    parameter int          TIMEOUT   = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            en_in,
    output logic [5:0]      num1,
    output logic [5:0]      num2,
    output logic [5:0]      num3,
    output logic [5:0]      num4,
    output logic [5:0]      num5,
    output logic [5:0]      num6,
    output logic [5:0]      num7,
    output logic [5:0]      num8,
    input  logic            en_out,
    input  logic [8:0]      result,
    output logic [8:0]      ideal,
    output logic [SUMW-1:0] mae_sum,
    output logic [9:0]      sample_cnt,
    output logic            busy,
    output logic            done,
    output logic            timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_CMP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [5:0] C_MID  = 6'd32;
    localparam int         C_TW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [C_TW-1:0] C_WAIT_LAST = C_TW'(TIMEOUT - 1);
    localparam logic [9:0] C_NSAMP = 10'(N_SAMPLES);

    state_t            state_q, state_d;
    logic              en_in_q, en_in_d;
    logic [5:0]        num_q [8];
    logic [5:0]        num_d [8];
    logic [47:0]       lfsr_q, lfsr_d;
    logic [8:0]        res_q, res_d;
    logic [SUMW-1:0]   mae_q, mae_d;
    logic [9:0]        cnt_q, cnt_d;
    logic [C_TW-1:0]   wait_q, wait_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;

    logic [11:0]       w_prod [4];
    logic [8:0]        w_ideal;
    logic [8:0]        w_diff;
    logic [SUMW:0]     w_sum_ext;
    logic [SUMW-1:0]   w_mae_add;
    logic [47:0]       w_lfsr_nxt;

    // Pairwise operand products for the reference dot product
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_prod[k] = 12'(num_q[2*k]) * 12'(num_q[2*k+1]);
        end
    end

    // Reference: each product is truncated by 6 bits before summing
    always_comb begin
        w_ideal = '0;
        for (int k = 0; k < 4; k++) begin
            w_ideal = w_ideal + {3'b000, w_prod[k][11:6]};
        end
    end

    // Absolute error and saturating accumulation, plus LFSR successor
    always_comb begin
        w_diff     = (w_ideal >= res_q) ? (w_ideal - res_q) : (res_q - w_ideal);
        w_sum_ext  = {1'b0, mae_q} + (SUMW+1)'(w_diff);
        w_mae_add  = w_sum_ext[SUMW] ? {SUMW{1'b1}} : w_sum_ext[SUMW-1:0];
        w_lfsr_nxt = {lfsr_q[46:0], lfsr_q[47] ^ lfsr_q[46] ^ lfsr_q[20] ^ lfsr_q[19]};
    end

    // Next-state logic for the run controller and all datapath registers
    always_comb begin
        state_d   = state_q;
        en_in_d   = 1'b0;
        num_d     = num_q;
        lfsr_d    = lfsr_q;
        res_d     = res_q;
        mae_d     = mae_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mae_d     = '0;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    lfsr_d    = SEED;
                    wait_d    = '0;
                    for (int i = 0; i < 8; i++) begin
                        num_d[i] = C_MID;
                    end
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                // A result arriving on the final wait cycle still counts
                if (en_out) begin
                    res_d   = result;
                    state_d = S_CMP;
                end else if (wait_q == C_WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    wait_d  = wait_q + 1'b1;
                    en_in_d = 1'b1;
                end
            end
            S_CMP: begin
                mae_d = w_mae_add;
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == C_NSAMP) begin
                    state_d = S_DONE;
                end else begin
                    lfsr_d = w_lfsr_nxt;
                    for (int i = 0; i < 8; i++) begin
                        num_d[i] = w_lfsr_nxt[6*i +: 6];
                    end
                    wait_d  = '0;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_REQ) || (state_d == S_CMP);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; reset forces the idle operand set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            en_in_q   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                num_q[i] <= C_MID;
            end
            lfsr_q    <= SEED;
            res_q     <= '0;
            mae_q     <= '0;
            cnt_q     <= '0;
            wait_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_in_q   <= en_in_d;
            num_q     <= num_d;
            lfsr_q    <= lfsr_d;
            res_q     <= res_d;
            mae_q     <= mae_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign en_in      = en_in_q;
    assign num1       = num_q[0];
    assign num2       = num_q[1];
    assign num3       = num_q[2];
    assign num4       = num_q[3];
    assign num5       = num_q[4];
    assign num6       = num_q[5];
    assign num7       = num_q[6];
    assign num8       = num_q[7];
    assign ideal      = w_ideal;
    assign mae_sum    = mae_q;
    assign sample_cnt = cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = timeout_q;

endmodule
`default_nettype wire

// File: doc/sc_dot_host.md
Name: sc_dot_host

Overview:
- Synthesizable requester and checker for the stochastic 4-term dot-product unit (Sobol SC core).
- Issues operand sets num1..num8 (6-bit, value/64) over the en_in/en_out handshake and captures each 9-bit result.
- Computes the exact truncated ideal for each set and accumulates absolute error over N_SAMPLES.
- Used for on-chip/FPGA MAE characterisation of the SC core.

Parameters:
N_SAMPLES, 1000, operand sets per run (1..1023)
SEED, 48'h5A5A_C3C3_0F0F, nonzero LFSR seed, reloaded on every start
SUMW, 20, error accumulator width
TIMEOUT, 255, max cycles spent in REQ waiting for en_out

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a run; ignored unless IDLE or DONE
en_in  out  1  request to SC core; operands valid while high
num1..num8  out  6 each  operand set presented to the core
en_out  in  1  core result valid
result  in  9  core dot-product result (x64 scaling)
ideal  out  9  exact reference for current set
mae_sum  out  SUMW  accumulated |ideal-result|
sample_cnt  out  10  completed samples in this run
busy  out  1  high in REQ or CMP
done  out  1  high in DONE
timeout  out  1  sticky until next start; set if TIMEOUT expires

Behaviour:
- Reset values: state=IDLE, en_in=0, num1..num8=32, LFSR=SEED, mae_sum=0, sample_cnt=0, done=0, busy=0, timeout=0. ideal is combinational from num1..num8, so it reads 64 out of reset.
- FSM states: IDLE, REQ, CMP, DONE.
- IDLE or DONE, start=1:
  - clear mae_sum, sample_cnt, timeout
  - reload LFSR=SEED
  - load num1..num8=32
  - go to REQ
- REQ:
  - en_in=1 (registered, asserted the cycle after entry); operands held stable.
  - Wait counter increments each cycle.
  - On posedge with en_out=1: capture result into res_q, go to CMP. en_in is low in CMP.
  - If the wait counter reaches TIMEOUT with no en_out: set timeout=1 and go to DONE, leaving sample_cnt unchanged.
- CMP (exactly one cycle):
  - mae_sum += |ideal - res_q|, saturating at 2^SUMW-1.
  - sample_cnt += 1.
  - If the new sample_cnt == N_SAMPLES, go to DONE.
  - Otherwise advance the LFSR once, load num1..num8 from the new LFSR bits [5:0],[11:6],...,[47:42] (num1 lowest), and go to REQ.
- DONE: done=1, outputs frozen. Hold until start or rst.
- Minimum per-sample cost: 2 cycles plus core latency. done rises the cycle after the final CMP.
- LFSR: 48-bit Fibonacci, taps 48,47,21,20, shifts left with feedback into bit 0. State 0 is unreachable.
- ideal = sum over k=1..4 of (num(2k-1)*num(2k))>>6.
  - Each term is truncated individually.
  - Maximum is 4*62 = 248, so it fits 9 bits.
- |ideal - res_q| is computed as a 9-bit unsigned difference, whichever operand is larger minus the smaller.
- en_out outside REQ: ignored; no capture, no count.
- start in REQ or CMP: ignored.
- start and en_out in the same cycle while in REQ: en_out wins.
- rst mid-run: immediate return to reset values; en_in drops asynchronously.

Test Plan:
- Reset, then idle 10 cycles with en_out toggling -> en_in=0, mae_sum=0, sample_cnt=0, done=0, ideal=64.
- N_SAMPLES=1, stub core returns result=64 one cycle after en_in -> num1..8=32, mae_sum=0, sample_cnt=1, done=1, en_in low after capture.
- N_SAMPLES=1, stub returns 60 -> mae_sum=4. Rerun via start, stub returns 70 -> mae_sum=6 (cleared between runs).
- N_SAMPLES=3, stub returns ideal+5 for each set -> mae_sum=15, sample_cnt=3, second set equals SEED advanced once (bench model).
- TIMEOUT=16, stub never asserts en_out -> timeout=1, done=1 after 16 REQ cycles, sample_cnt=0.
- N_SAMPLES=1023, stub returns ideal XOR 9'h1FF -> mae_sum matches bench model and never wraps (saturation path exercised with SUMW=10 variant: mae_sum=1023).
